systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Sits between the im2col stage and `systolic_array`.
- After im2col completes, reads the weight matrix and the im2col matrix from shared memory through the registered read port. Buffers them row-wise internally.
- Then streams one N-row per cycle onto the array's X/W inputs, replacing the top-level buffer/counter feed logic.
- Signals `done` when the stream ends and X has been zeroed.

Parameters:
- M, 4, im2col columns per row (IMG_H*IMG_W); X lanes
- N, 1, reduction length (FILTER_SIZE^2*IMG_C); rows streamed
- K, 1, filter count; W lanes
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, memory address width
- WEIGHT_BASE, 32'h00001000, base of weight matrix, word i*K+j = W[i][j]
- IM2COL_BASE, 32'h00002000, base of im2col matrix, word i*M+j = X[i][j]

Ports:
- clk  in  1  clock
- rst_systolic  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin load+feed
- addr_rd  out  ADDR_WIDTH  memory read address
- data_rd  in  DATA_WIDTH  memory data; word for addr_rd sampled at edge t is valid to capture at edge t+1
- X  out  DATA_WIDTH*M  lane j = bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
- W  out  DATA_WIDTH*K  lane j, same packing
- feed_valid  out  1  high during cycles X/W carry a real row
- busy  out  1  high in LOAD, FLUSH, FEED
- done  out  1  level, high in DONE

Behaviour:
- Reset (async, rst_systolic=0): state=IDLE, idx=0, row=0, X=0, W=0, feed_valid=0, busy=0, done=0. Buffer contents are not cleared. Applies at any point, including mid-LOAD or mid-FEED; the next start re-runs from scratch.
- States: IDLE, LOAD, FLUSH, FEED, DONE.
- IDLE:
  - addr_rd=WEIGHT_BASE.
  - start=1 -> LOAD, idx=0.
- LOAD:
  - Lasts L = N*K + N*M cycles.
  - addr_rd is combinational from idx: idx<N*K -> WEIGHT_BASE+idx; else IM2COL_BASE+(idx-N*K).
  - idx increments each edge.
  - Capture pipeline: cap_valid/cap_idx registered from (LOAD, idx). When cap_valid=1, data_rd goes to W_buf[cap_idx/K][cap_idx%K] for cap_idx<N*K, else to X_buf[(cap_idx-N*K)/M][(cap_idx-N*K)%M].
  - idx==L-1 -> FLUSH.
- FLUSH:
  - 1 cycle; the last word is captured.
  - Then FEED, row=0.
- FEED:
  - At each edge in FEED: X<=X_buf[row], W<=W_buf[row], feed_valid<=1, row++.
  - After the edge loading row N-1 -> DONE.
  - Exactly N cycles with feed_valid=1, rows in order 0..N-1.
- DONE:
  - On entry edge: X<=0, feed_valid<=0. W holds the last row (array tolerates a stale W when X=0).
  - done=1, busy=0.
  - start=1 -> LOAD (restart, done drops next edge).
- Timing:
  - Start sampled at edge E0. First feed_valid=1 cycle follows edge E0+L+2. done=1 after edge E0+L+2+N.
- start is ignored while busy.
- Address arithmetic is unsigned ADDR_WIDTH with no wrap checks; the caller guarantees bases plus sizes fit in memory.
- Buffers: X_buf N x (DATA_WIDTH*M), W_buf N x (DATA_WIDTH*K), registers only.
- No combinational path from data_rd to any output.

Test Plan:
- Defaults M=4,N=1,K=1. mem[0x1000]=5, mem[0x2000..0x2003]=1,2,3,4; start at E0.
  -> addr_rd sequence 0x1000,0x2000,0x2001,0x2002,0x2003.
  -> After E7: X=0x00000004_00000003_00000002_00000001, W=5, feed_valid=1 for exactly one cycle.
  -> After E8: X=0, done=1.
- M=2,N=3,K=2. Weights 0x1000..0x1005 = 10..15; im2col 0x2000..0x2005 = 1..6.
  -> Rows fed in order: X={2,1},W={11,10}; X={4,3},W={13,12}; X={6,5},W={15,14}.
  -> feed_valid high 3 consecutive cycles, then done.
- start pulsed again during LOAD and during FEED.
  -> Ignored; addr sequence and timing identical to a single run.
- rst_systolic asserted mid-FEED (after row 1 of 3).
  -> X=0, W=0, feed_valid=0, busy=0 immediately (async).
  -> Later start gives a full correct run.
- start while done=1, with memory changed (mem[0x1000]=7).
  -> Reloads; new W=7 observed; done low during the rerun, high again at the end.
- Memory data with upper bit set (0xFFFFFFFF, 0x80000000).
  -> Passed through unmodified on the correct lanes.

Source files
------------

// File: rtl/systolic_feeder.sv
// Loads the weight and im2col matrices from memory into row buffers, then
// streams one reduction row per cycle onto the systolic array X/W inputs.
module systolic_feeder #(
  parameter int M = 4,
  parameter int N = 1,
  parameter int K = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = ADDR_WIDTH'(32'h00001000),
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(32'h00002000)
) (
  input  logic                    clk,
  input  logic                    rst_systolic,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   addr_rd,
  input  logic [DATA_WIDTH-1:0]   data_rd,
  output logic [DATA_WIDTH*M-1:0] X,
  output logic [DATA_WIDTH*K-1:0] W,
  output logic                    feed_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int NK        = N * K;
  localparam int NM        = N * M;
  localparam int L         = NK + NM;
  localparam int IDX_W     = $clog2(L);
  localparam int ROW_W     = $clog2(N + 1);
  localparam int ROW_SEL_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_FEED, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ROW_SEL_W-1:0]    row_sel;
  logic                    cap_valid_q, cap_valid_d;
  logic [IDX_W-1:0]        cap_idx_q, cap_idx_d;
  logic [DATA_WIDTH*M-1:0] x_q, x_d;
  logic [DATA_WIDTH*K-1:0] w_q, w_d;
  logic                    fv_q, fv_d;
  logic [DATA_WIDTH*M-1:0] x_buf_q [N];
  logic [DATA_WIDTH*M-1:0] x_buf_d [N];
  logic [DATA_WIDTH*K-1:0] w_buf_q [N];
  logic [DATA_WIDTH*K-1:0] w_buf_d [N];

  assign row_sel = row_q[ROW_SEL_W-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    x_d     = x_q;
    w_d     = w_q;
    fv_d    = fv_q;
    addr_rd = WEIGHT_BASE;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (idx_q < IDX_W'(NK)) addr_rd = WEIGHT_BASE + ADDR_WIDTH'(idx_q);
        else                    addr_rd = IM2COL_BASE + ADDR_WIDTH'(idx_q - IDX_W'(NK));
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(L - 1)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_FEED;
        row_d   = '0;
      end
      S_FEED: begin
        if (row_q < ROW_W'(N)) begin
          x_d   = x_buf_q[row_sel];
          w_d   = w_buf_q[row_sel];
          fv_d  = 1'b1;
          row_d = row_q + ROW_W'(1);
        end else begin
          // W is left on the last row; the array ignores it once X is zero.
          x_d     = '0;
          fv_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lags its address by one edge, so capture uses a delayed index.
  always_comb begin
    cap_valid_d = (state_q == S_LOAD);
    cap_idx_d   = idx_q;
    x_buf_d     = x_buf_q;
    w_buf_d     = w_buf_q;
    if (cap_valid_q) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < K; c++) begin
          if (cap_idx_q == IDX_W'(r * K + c))
            w_buf_d[r][c*DATA_WIDTH +: DATA_WIDTH] = data_rd;
        end
        for (int c = 0; c < M; c++) begin
          if (cap_idx_q == IDX_W'(NK + r * M + c))
            x_buf_d[r][c*DATA_WIDTH +: DATA_WIDTH] = data_rd;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_systolic) begin
    if (!rst_systolic) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      row_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      x_q         <= '0;
      w_q         <= '0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      x_q         <= x_d;
      w_q         <= w_d;
      fv_q        <= fv_d;
    end
  end

  always_ff @(posedge clk) begin
    x_buf_q <= x_buf_d;
    w_buf_q <= w_buf_d;
  end

  assign X          = x_q;
  assign W          = w_q;
  assign feed_valid = fv_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_FEED);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a default-size instance and an M=2,N=3,K=2 instance
// fed from a small registered-read memory model.
module tb_systolic_feeder;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MA = 4, NA = 1, KA = 1;
  localparam int MB = 2, NB = 3, KB = 2;
  localparam int LB = NB * KB + NB * MB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] wmem [16];
  logic [DW-1:0] xmem [16];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a[AW-1:4] == 28'h0000100) return wmem[a[3:0]];
    if (a[AW-1:4] == 28'h0000200) return xmem[a[3:0]];
    return '0;
  endfunction

  logic             rst_a = 1'b1, start_a = 1'b0, fv_a, busy_a, done_a;
  logic [AW-1:0]    addr_a;
  logic [DW-1:0]    data_a = '0;
  logic [DW*MA-1:0] x_a;
  logic [DW*KA-1:0] w_a;

  logic             rst_b = 1'b1, start_b = 1'b0, fv_b, busy_b, done_b;
  logic [AW-1:0]    addr_b;
  logic [DW-1:0]    data_b = '0;
  logic [DW*MB-1:0] x_b;
  logic [DW*KB-1:0] w_b;

  systolic_feeder #(.M(MA), .N(NA), .K(KA)) dut_a (
    .clk(clk), .rst_systolic(rst_a), .start(start_a), .addr_rd(addr_a), .data_rd(data_a),
    .X(x_a), .W(w_a), .feed_valid(fv_a), .busy(busy_a), .done(done_a));

  systolic_feeder #(.M(MB), .N(NB), .K(KB)) dut_b (
    .clk(clk), .rst_systolic(rst_b), .start(start_b), .addr_rd(addr_b), .data_rd(data_b),
    .X(x_b), .W(w_b), .feed_valid(fv_b), .busy(busy_b), .done(done_b));

  always @(posedge clk) begin
    data_a <= mem_rd(addr_a);
    data_b <= mem_rd(addr_b);
  end

  task automatic test_reset();
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    checks++; if (x_a !== '0) begin errors++; $display("FAIL reset_x_a got=%h want=0", x_a); end
    checks++; if (w_a !== '0) begin errors++; $display("FAIL reset_w_a got=%h want=0", w_a); end
    checks++; if ({fv_a, busy_a, done_a} !== 3'b000) begin errors++; $display("FAIL reset_flags_a got=%b want=000", {fv_a, busy_a, done_a}); end
    checks++; if (addr_a !== 32'h1000) begin errors++; $display("FAIL reset_addr_a got=%h want=1000", addr_a); end
    checks++; if (x_b !== '0 || w_b !== '0) begin errors++; $display("FAIL reset_xw_b got=%h/%h want=0/0", x_b, w_b); end
    checks++; if ({fv_b, busy_b, done_b} !== 3'b000) begin errors++; $display("FAIL reset_flags_b got=%b want=000", {fv_b, busy_b, done_b}); end
    repeat (2) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_config();
    logic [AW-1:0]    ea [5];
    logic [DW*MA-1:0] ex;
    ea = '{32'h1000, 32'h2000, 32'h2001, 32'h2002, 32'h2003};
    ex = 128'h00000004_00000003_00000002_00000001;
    wmem[0] = 32'd5;
    for (int i = 0; i < 4; i++) xmem[i] = DW'(i + 1);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (addr_a !== ea[k]) begin errors++; $display("FAIL dflt_addr[%0d] got=%h want=%h", k, addr_a, ea[k]); end
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL dflt_fv_early got=%b want=0", fv_a); end
    @(negedge clk);
    checks++; if (fv_a !== 1'b1) begin errors++; $display("FAIL dflt_fv got=%b want=1", fv_a); end
    checks++; if (x_a !== ex) begin errors++; $display("FAIL dflt_x got=%h want=%h", x_a, ex); end
    checks++; if (w_a !== 32'd5) begin errors++; $display("FAIL dflt_w got=%h want=5", w_a); end
    @(negedge clk);
    checks++; if (x_a !== '0 || fv_a !== 1'b0) begin errors++; $display("FAIL dflt_end_x got=%h fv=%b want=0 fv=0", x_a, fv_a); end
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL dflt_done got done=%b busy=%b want 1/0", done_a, busy_a); end
  endtask

  // Full run on dut_b with cycle-exact checks; optional extra start pulses while busy.
  task automatic test_stream(input string tag, input bit pulse);
    logic [AW-1:0]    exp_addr [$];
    logic [DW*MB-1:0] ex;
    logic [DW*KB-1:0] ew;
    logic             e_fv, e_busy, e_done;
    int               r;
    exp_addr = {};
    for (int i = 0; i < NB * KB; i++) exp_addr.push_back(32'h1000 + i);
    for (int i = 0; i < NB * MB; i++) exp_addr.push_back(32'h2000 + i);
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < LB + NB + 3; c++) begin
      e_fv   = (c >= LB + 2) && (c < LB + 2 + NB);
      e_busy = (c < LB + 2 + NB);
      e_done = (c >= LB + 2 + NB);
      r      = e_fv ? c - LB - 2 : NB - 1;
      for (int j = 0; j < MB; j++) ex[j*DW +: DW] = e_fv ? xmem[r*MB + j] : '0;
      for (int j = 0; j < KB; j++) ew[j*DW +: DW] = wmem[r*KB + j];
      if (c < LB) begin
        checks++; if (addr_b !== exp_addr[c]) begin errors++; $display("FAIL %s addr c=%0d got=%h want=%h", tag, c, addr_b, exp_addr[c]); end
      end
      checks++; if ({fv_b, busy_b, done_b} !== {e_fv, e_busy, e_done})
        begin errors++; $display("FAIL %s flags c=%0d got fv/busy/done=%b want=%b", tag, c, {fv_b, busy_b, done_b}, {e_fv, e_busy, e_done}); end
      if (e_fv || e_done) begin
        checks++; if (x_b !== ex) begin errors++; $display("FAIL %s x c=%0d got=%h want=%h", tag, c, x_b, ex); end
        checks++; if (w_b !== ew) begin errors++; $display("FAIL %s w c=%0d got=%h want=%h", tag, c, w_b, ew); end
      end
      start_b = pulse && (c == 3 || c == LB + 3);
      @(negedge clk);
    end
    start_b = 1'b0;
  endtask

  task automatic test_fixed_values();
    for (int i = 0; i < 6; i++) begin
      wmem[i] = DW'(10 + i);
      xmem[i] = DW'(1 + i);
    end
    test_stream("fixed", 1'b0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      wmem[i] = $urandom;
      xmem[i] = $urandom;
    end
  endtask

  task automatic test_random_runs();
    for (int n = 0; n < 3; n++) begin
      fill_random();
      test_stream("random", 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    test_stream("start_ignored", 1'b1);
  endtask

  task automatic test_sign_bits();
    for (int i = 0; i < 16; i++) begin
      wmem[i] = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h80000000;
      xmem[i] = (i % 2 == 0) ? 32'h80000000 : 32'hFFFFFFFF;
    end
    test_stream("sign_bits", 1'b0);
  endtask

  task automatic test_reset_mid_feed();
    fill_random();
    @(negedge clk); start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
    repeat (LB + 3) @(negedge clk);
    checks++; if (fv_b !== 1'b1) begin errors++; $display("FAIL midrst_pre_fv got=%b want=1", fv_b); end
    #2 rst_b = 1'b0;
    #1;
    checks++; if (x_b !== '0 || w_b !== '0) begin errors++; $display("FAIL midrst_xw got=%h/%h want=0/0", x_b, w_b); end
    checks++; if ({fv_b, busy_b, done_b} !== 3'b000) begin errors++; $display("FAIL midrst_flags got=%b want=000", {fv_b, busy_b, done_b}); end
    @(negedge clk); rst_b = 1'b1;
    fill_random();
    test_stream("after_reset", 1'b0);
  endtask

  task automatic test_restart_from_done();
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL restart_pre_done got=%b want=1", done_b); end
    wmem[0] = 32'd7;
    test_stream("restart", 1'b0);
  endtask

  initial begin
    test_reset();
    test_default_config();
    test_fixed_values();
    test_random_runs();
    test_start_ignored();
    test_sign_bits();
    test_reset_mid_feed();
    test_restart_from_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
